// File: rtl/sym_pattern_matcher.sv
// Sliding-window matcher for a stream of 2-bit symbols against a loadable N-symbol pattern.
// Emits a registered one-cycle match pulse and keeps a saturating count of matches.
module sym_pattern_matcher #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [2*N-1:0]   pat_in,
    input  logic             sym_valid,
    input  logic [1:0]       sym,
    output logic             armed,
    output logic             match_tick,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2*N-1:0]     r_pattern;
    logic [2*N-1:0]     r_window;
    logic [FW-1:0]      r_fill;
    logic               r_armed;
    logic               r_tick;
    logic [CNT_W-1:0]   r_cnt;

    logic [2*N-1:0]     w_win_next;
    logic [N-1:0]       w_sym_eq;
    logic               w_fill_done;
    logic               w_full_accept;
    logic               w_match;
    logic               w_cnt_sat;

    assign w_win_next = {r_window[2*N-3:0], sym};

    // Per-symbol equality; the full match is the AND across all N lanes.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sym_eq
            assign w_sym_eq[gi] = (w_win_next[2*gi +: 2] == r_pattern[2*gi +: 2]);
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_fill_done   = (r_state == ST_FILL) && (r_fill == FILL_LAST);
        // Compare only on an accept that leaves the window holding N real symbols.
        w_full_accept = sym_valid && ((r_state == ST_RUN) || w_fill_done);
        w_match       = w_full_accept && (&w_sym_eq);
        w_cnt_sat     = (r_cnt == {CNT_W{1'b1}});
        if (sym_valid && w_fill_done) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FILL;
            r_pattern <= '0;
            r_window  <= '0;
            r_fill    <= '0;
            r_armed   <= 1'b0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
        end else if (load) begin
            // A symbol presented alongside load is intentionally dropped.
            r_state   <= ST_FILL;
            r_pattern <= pat_in;
            r_window  <= '0;
            r_fill    <= '0;
            r_armed   <= 1'b0;
            r_tick    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            r_armed <= (w_state_next == ST_RUN);
            r_tick  <= w_match;
            if (sym_valid) begin
                r_window <= w_win_next;
                if ((r_state == ST_FILL) && !w_fill_done) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
            if (w_match && !w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign armed      = r_armed;
    assign match_tick = r_tick;
    assign match_cnt  = r_cnt;

endmodule

// File: tb/tb_sym_pattern_matcher.sv
// Randomised and directed bench for sym_pattern_matcher; a queue-based model of the
// last N accepted symbols predicts armed / match_tick / match_cnt on every cycle.
module tb_sym_pattern_matcher;

    localparam int N       = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load = 1'b0;
    logic [2*N-1:0]   pat_in = '0;
    logic             sym_valid = 1'b0;
    logic [1:0]       sym = '0;
    logic             armed;
    logic             match_tick;
    logic [CNT_W-1:0] match_cnt;

    sym_pattern_matcher #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pat_in     (pat_in),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .armed      (armed),
        .match_tick (match_tick),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;
    int tick_total = 0;

    // Model: pattern as a list of symbols (oldest first) and the accepted history.
    int m_pat[N];
    int m_hist[$];
    int m_cnt  = 0;
    int m_tick = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n_cycle);
    endtask

    task automatic model_edge();
        bit all_eq;
        if (reset) begin
            for (int i = 0; i < N; i++) m_pat[i] = 0;
            m_hist.delete();
            m_cnt  = 0;
            m_tick = 0;
        end else if (load) begin
            for (int i = 0; i < N; i++) m_pat[i] = int'(pat_in[2*(N-1-i) +: 2]);
            m_hist.delete();
            m_cnt  = 0;
            m_tick = 0;
        end else if (sym_valid) begin
            m_hist.push_back(int'(sym));
            if (m_hist.size() > N) void'(m_hist.pop_front());
            all_eq = (m_hist.size() == N);
            if (all_eq) begin
                for (int i = 0; i < N; i++) if (m_hist[i] != m_pat[i]) all_eq = 0;
            end
            m_tick = all_eq ? 1 : 0;
            if (all_eq && m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_tick = 0;
        end
    endtask

    // One clock: drive inputs, advance model, compare outputs 1 time unit after the edge.
    task automatic cyc(input logic r, input logic l, input logic [2*N-1:0] p,
                       input logic v, input logic [1:0] s);
        reset = r; load = l; pat_in = p; sym_valid = v; sym = s;
        model_edge();
        @(posedge clk);
        #1;
        n_cycle++;
        chk("armed", 32'(armed), 32'((m_hist.size() == N) ? 1 : 0));
        chk("match_tick", 32'(match_tick), 32'(m_tick));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        if (match_tick === 1'b1) tick_total++;
        $display("cyc %0d rst=%0b ld=%0b v=%0b s=%0d -> armed=%0b tick=%0b cnt=%0d",
                 n_cycle, r, l, v, s, armed, match_tick, match_cnt);
    endtask

    task automatic feed(input logic [1:0] s);
        cyc(1'b0, 1'b0, '0, 1'b1, s);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, 1'b0, 2'd0);
    endtask

    task automatic do_load(input logic [2*N-1:0] p);
        cyc(1'b0, 1'b1, p, 1'b0, 2'd0);
    endtask

    initial begin
        int base;
        logic [2*N-1:0] rp;

        // Reset state
        do_reset();
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);

        // Basic match on pattern 0,1,2,3
        do_load(8'b00_01_10_11);
        feed(2'd0); feed(2'd1); feed(2'd2);
        chk("t1_armed_pre", 32'(armed), 32'd0);
        chk("t1_tick_pre", 32'(match_tick), 32'd0);
        feed(2'd3);
        chk("t1_tick", 32'(match_tick), 32'd1);
        chk("t1_armed", 32'(armed), 32'd1);
        chk("t1_cnt", 32'(match_cnt), 32'd1);
        idle();
        chk("t1_tick_drop", 32'(match_tick), 32'd0);

        // Fill guard after reset: pattern is zero
        do_reset();
        feed(2'd0); feed(2'd0); feed(2'd0);
        chk("t2_tick_pre", 32'(match_tick), 32'd0);
        chk("t2_armed_pre", 32'(armed), 32'd0);
        feed(2'd0);
        chk("t2_tick", 32'(match_tick), 32'd1);
        chk("t2_cnt", 32'(match_cnt), 32'd1);

        // Overlapping matches with idle gaps
        do_load(8'b01_01_01_01);
        base = tick_total;
        feed(2'd1); idle(); feed(2'd1); feed(2'd1); idle(); feed(2'd1);
        idle(); feed(2'd1); feed(2'd1); idle();
        chk("t3_ticks", 32'(tick_total - base), 32'd3);
        chk("t3_cnt", 32'(match_cnt), 32'd3);

        // Saturation of the 2-bit counter
        do_load(8'hFF);
        base = tick_total;
        for (int i = 0; i < 8; i++) feed(2'd3);
        idle();
        chk("t4_ticks", 32'(tick_total - base), 32'd5);
        chk("t4_cnt", 32'(match_cnt), 32'd3);

        // Load collision: symbol presented with load is dropped
        do_load(8'b00_01_10_11);
        for (int r = 0; r < 2; r++) begin
            feed(2'd0); feed(2'd1); feed(2'd2); feed(2'd3);
        end
        chk("t5_cnt_pre", 32'(match_cnt), 32'd2);
        feed(2'd0); feed(2'd1); feed(2'd2);
        cyc(1'b0, 1'b1, 8'b00_01_10_11, 1'b1, 2'd3);
        chk("t5_tick_ld", 32'(match_tick), 32'd0);
        chk("t5_cnt_ld", 32'(match_cnt), 32'd0);
        chk("t5_armed_ld", 32'(armed), 32'd0);
        feed(2'd0); feed(2'd1); feed(2'd2);
        chk("t5_armed_3", 32'(armed), 32'd0);
        feed(2'd3);
        chk("t5_tick_fresh", 32'(match_tick), 32'd1);

        // Reset mid-stream clears the pattern
        do_load(8'b00_01_10_11);
        feed(2'd0); feed(2'd1);
        do_reset();
        base = tick_total;
        feed(2'd2); feed(2'd3);
        chk("t6_ticks_none", 32'(tick_total - base), 32'd0);
        feed(2'd0); feed(2'd0); feed(2'd0);
        chk("t6_tick_pre", 32'(match_tick), 32'd0);
        feed(2'd0);
        chk("t6_tick", 32'(match_tick), 32'd1);

        // Random traffic; symbols biased towards 0/1 so matches are frequent
        for (int i = 0; i < 800; i++) begin
            int roll;
            logic [1:0] s;
            roll = int'($urandom_range(0, 99));
            s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if (roll < 1) begin
                do_reset();
            end else if (roll < 4) begin
                for (int k = 0; k < N; k++) rp[2*k +: 2] = 2'($urandom_range(0, 1));
                cyc(1'b0, 1'b1, rp, 1'($urandom_range(0, 1)), s);
            end else if (roll < 75) begin
                feed(s);
            end else begin
                cyc(1'b0, 1'b0, 8'($urandom), 1'b0, s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
